usb_mch_regs: RTL

//  APB3 register slave serving NUM_CH independent USB FIFO channels; one module replaces per-channel

---
 rtl/usb_mch_regs_pkg.sv | 35 +++
 rtl/usb_mch_regs_if.sv | 31 +++
 rtl/usb_mch_slice.sv | 157 +++++++++++++++
 rtl/usb_mch_regs.sv | 94 +++++++++
 4 files changed

// File: rtl/usb_mch_regs_pkg.sv
// ============================================================================
//  Module      : usb_mch_regs_pkg
//  Description : Register map, STATUS bit positions and prefetch FSM states
//                shared by the multi-channel USB FIFO register slave.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package usb_mch_regs_pkg;

    localparam logic [7:0] OFF_WR_MUX   = 8'h00;
    localparam logic [7:0] OFF_WR_DATA  = 8'h04;
    localparam logic [7:0] OFF_WR_BE    = 8'h08;
    localparam logic [7:0] OFF_WR_PUSH  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_ATRIG    = 8'h14;
    localparam logic [7:0] OFF_RD_DATA  = 8'h18;
    localparam logic [7:0] OFF_RD_MUX   = 8'h1C;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h20;

    localparam int ST_WR_FULL  = 0;
    localparam int ST_RD_EMPTY = 1;
    localparam int ST_RD_VALID = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_UDF      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/usb_mch_regs_if.sv
// ============================================================================
//  Module      : usb_mch_regs_if
//  Description : APB3 bus bundle between the host bridge and the register slave.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface usb_mch_regs_if #(
    parameter int ADDR_W = 40
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

`default_nettype wire

// File: rtl/usb_mch_slice.sv
// ============================================================================
//  Module      : usb_mch_slice
//  Description : One channel: staging regs, push timer, read prefetch, sticky flags.
//                IRQ_MASK exists only when USB_MCH_REGS_IRQ_EN is defined.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module usb_mch_slice
    import usb_mch_regs_pkg::*;
#(
    parameter int CH_STRIDE_LOG2 = 6,
    parameter int TRIG_W         = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      acc_i,
    input  logic                      pwrite_i,
    input  logic [CH_STRIDE_LOG2-1:0] off_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               rdata_o,
    output logic [3:0]                wr_mux_o,
    output logic [31:0]               wr_data_o,
    output logic [3:0]                wr_be_o,
    output logic                      wr_en_o,
    output logic                      wr_push_o,
    input  logic                      wr_full_i,
    output logic [3:0]                rd_mux_o,
    input  logic [31:0]               rd_data_i,
    output logic                      rd_en_o,
    input  logic                      rd_empty_i,
    output logic                      irq_src_o
);
    logic [7:0]        w_off;
    logic              w_wr, w_rd_pop, w_manual, w_auto, w_rd_en;
    logic [3:0]        wr_mux_q, wr_be_cfg_q, wr_be_q, rd_mux_q;
    logic [31:0]       wr_data_q, hold_q;
    logic              wr_en_q, wr_push_q, ovf_q, udf_q;
    logic [TRIG_W-1:0] atrig_q, cnt_q;
    rd_state_e         state_q, state_d;

    assign w_off    = 8'(off_i);
    assign w_wr     = acc_i & pwrite_i;
    assign w_rd_pop = acc_i & ~pwrite_i & (w_off == OFF_RD_DATA);
    assign w_manual = w_wr & (w_off == OFF_WR_PUSH);
    assign w_auto   = (atrig_q != '0) && (cnt_q == atrig_q - TRIG_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_mux_q    <= '0;
            wr_be_cfg_q <= 4'hF;
            wr_be_q     <= '0;
            rd_mux_q    <= '0;
            wr_data_q   <= '0;
            hold_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_push_q   <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            atrig_q     <= '0;
            cnt_q       <= '0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_push_q <= w_manual | w_auto;
            if (w_wr && w_off == OFF_WR_MUX) wr_mux_q    <= pwdata_i[3:0];
            if (w_wr && w_off == OFF_WR_BE)  wr_be_cfg_q <= pwdata_i[3:0];
            if (w_wr && w_off == OFF_RD_MUX) rd_mux_q    <= pwdata_i[3:0];
            if (w_wr && w_off == OFF_STATUS) begin
                if (pwdata_i[ST_OVF]) ovf_q <= 1'b0;
                if (pwdata_i[ST_UDF]) udf_q <= 1'b0;
            end
            if (w_wr && w_off == OFF_WR_DATA) begin
                wr_data_q <= pwdata_i;
                wr_be_q   <= wr_be_cfg_q;
                if (wr_full_i) ovf_q   <= 1'b1;
                else           wr_en_q <= 1'b1;
            end
            if (w_rd_pop && state_q != VALID) udf_q <= 1'b1;
            // A manual push coinciding with the auto hit still restarts the period.
            if (w_wr && w_off == OFF_ATRIG) begin
                atrig_q <= pwdata_i[TRIG_W-1:0];
                cnt_q   <= '0;
            end else if (atrig_q == '0 || w_auto) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + TRIG_W'(1);
            end
            if (state_q == FETCH) hold_q <= rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        w_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rd_empty_i) begin
                    state_d = FETCH;
                    w_rd_en = 1'b1;
                end
            end
            FETCH:   state_d = VALID;
            VALID:   if (w_rd_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop is combinational from IDLE so the word arrives exactly in FETCH.
    assign rd_en_o   = w_rd_en & ~reset;
    assign wr_mux_o  = wr_mux_q;
    assign wr_data_o = wr_data_q;
    assign wr_be_o   = wr_be_q;
    assign wr_en_o   = wr_en_q;
    assign wr_push_o = wr_push_q;
    assign rd_mux_o  = rd_mux_q;

`ifdef USB_MCH_REGS_IRQ_EN
    logic [1:0] mask_q;
    always_ff @(posedge clk) begin
        if (reset)                          mask_q <= '0;
        else if (w_wr && w_off == OFF_IRQ_MASK) mask_q <= pwdata_i[1:0];
    end
    assign irq_src_o = |({udf_q, ovf_q} & mask_q);
`else
    assign irq_src_o = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        case (w_off)
            OFF_WR_MUX: rdata_o[3:0] = wr_mux_q;
            OFF_WR_BE:  rdata_o[3:0] = wr_be_cfg_q;
            OFF_STATUS: begin
                rdata_o[ST_WR_FULL]  = wr_full_i;
                rdata_o[ST_RD_EMPTY] = rd_empty_i;
                rdata_o[ST_RD_VALID] = (state_q == VALID);
                rdata_o[ST_OVF]      = ovf_q;
                rdata_o[ST_UDF]      = udf_q;
            end
            OFF_ATRIG:   rdata_o[TRIG_W-1:0] = atrig_q;
            OFF_RD_DATA: if (state_q == VALID) rdata_o = hold_q;
            OFF_RD_MUX:  rdata_o[3:0] = rd_mux_q;
`ifdef USB_MCH_REGS_IRQ_EN
            OFF_IRQ_MASK: rdata_o[1:0] = mask_q;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/usb_mch_regs.sv
// ============================================================================
//  Module      : usb_mch_regs
//  Description : APB3 register slave for NUM_CH USB FIFO channels; channel decode,
//                read mux, slave error and irq (USB_MCH_REGS_IRQ_EN enables irq).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module usb_mch_regs
    import usb_mch_regs_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = 40,
    parameter int CH_STRIDE_LOG2 = 6,
    parameter int TRIG_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    usb_mch_regs_if.slave         apb,
    output logic [4*NUM_CH-1:0]   wr_mux,
    output logic [32*NUM_CH-1:0]  wr_data,
    output logic [4*NUM_CH-1:0]   wr_be,
    output logic [NUM_CH-1:0]     wr_en,
    output logic [NUM_CH-1:0]     wr_push,
    input  logic [NUM_CH-1:0]     wr_full,
    output logic [4*NUM_CH-1:0]   rd_mux,
    input  logic [32*NUM_CH-1:0]  rd_data,
    output logic [NUM_CH-1:0]     rd_en,
    input  logic [NUM_CH-1:0]     rd_empty,
    output logic                  irq
);
    logic [2:0]        w_ch;
    logic              w_acc, w_ch_ok;
    logic [31:0]       w_rdata [NUM_CH];
    logic [NUM_CH-1:0] w_irq_src;

    assign w_ch        = apb.paddr[CH_STRIDE_LOG2 +: 3];
    assign w_acc       = apb.psel & apb.penable;
    assign w_ch_ok     = {1'b0, w_ch} < 4'(NUM_CH);
    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_acc & ~w_ch_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        usb_mch_slice #(
            .CH_STRIDE_LOG2 (CH_STRIDE_LOG2),
            .TRIG_W         (TRIG_W)
        ) u_slice (
            .clk        (clk),
            .reset      (reset),
            .acc_i      (w_acc && (w_ch == 3'(i))),
            .pwrite_i   (apb.pwrite),
            .off_i      (apb.paddr[CH_STRIDE_LOG2-1:0]),
            .pwdata_i   (apb.pwdata),
            .rdata_o    (w_rdata[i]),
            .wr_mux_o   (wr_mux[4*i +: 4]),
            .wr_data_o  (wr_data[32*i +: 32]),
            .wr_be_o    (wr_be[4*i +: 4]),
            .wr_en_o    (wr_en[i]),
            .wr_push_o  (wr_push[i]),
            .wr_full_i  (wr_full[i]),
            .rd_mux_o   (rd_mux[4*i +: 4]),
            .rd_data_i  (rd_data[32*i +: 32]),
            .rd_en_o    (rd_en[i]),
            .rd_empty_i (rd_empty[i]),
            .irq_src_o  (w_irq_src[i])
        );
    end

    // Out-of-range channels match no slice, so they read back zero.
    always_comb begin
        apb.prdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 3'(i)) apb.prdata = w_rdata[i];
        end
    end

`ifdef USB_MCH_REGS_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |w_irq_src;
    end
    assign irq = irq_q;
    logic w_unused;
    assign w_unused = ^apb.paddr[ADDR_W-1:CH_STRIDE_LOG2+3];
`else
    assign irq = 1'b0;
    logic w_unused;
    assign w_unused = ^{apb.paddr[ADDR_W-1:CH_STRIDE_LOG2+3], w_irq_src};
`endif

endmodule

`default_nettype wire
